// File: rtl/alu_pkg.sv
// Shared opcode and FSM state types for seq_alu and its iterative multiply/divide engine.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_MUL  = 4'b0010,
        ALU_DIV  = 4'b0011,
        ALU_SLL1 = 4'b0100,
        ALU_SRL1 = 4'b0101,
        ALU_SLLV = 4'b0110,
        ALU_SRLV = 4'b0111,
        ALU_AND  = 4'b1000,
        ALU_OR   = 4'b1001,
        ALU_XOR  = 4'b1010,
        ALU_NOR  = 4'b1011,
        ALU_REM  = 4'b1100,
        ALU_SLT  = 4'b1110,
        ALU_SEQ  = 4'b1111
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } alu_state_t;

    function automatic logic is_iterative(input logic [3:0] op);
        logic it;
        case (op)
            ALU_MUL, ALU_DIV, ALU_REM: it = 1'b1;
            default:                   it = 1'b0;
        endcase
        return it;
    endfunction

endpackage

// File: rtl/iter_muldiv.sv
// One-bit-per-cycle shift-add multiplier and restoring divider for seq_alu.
// ALU_OVERFLOW_EN widens the product accumulator to 2*WIDTH and exposes prod_hi_nz.
module iter_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] quo_prod,
    output logic [WIDTH-1:0] rem
`ifdef ALU_OVERFLOW_EN
    ,
    output logic             prod_hi_nz
`endif
);

    localparam int CW = $clog2(WIDTH);
`ifdef ALU_OVERFLOW_EN
    localparam int PW = 2 * WIDTH;
`else
    localparam int PW = WIDTH;
`endif

    logic             busy_r;
    logic             div_r;
    logic [CW-1:0]    cnt_r;
    logic [PW-1:0]    mcand_r;
    logic [PW-1:0]    acc_r;
    logic [PW-1:0]    acc_next_s;
    logic [WIDTH-1:0] shreg_r;
    logic [WIDTH-1:0] divisor_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH:0]   r_shift_s;
    logic [WIDTH-1:0] rem_next_s;
    logic [WIDTH-1:0] q_next_s;

    // shreg_r is the multiplier (shifting right) or the dividend turning into the quotient (shifting left)
    always_comb begin
        if (shreg_r[0]) begin
            acc_next_s = acc_r + mcand_r;
        end else begin
            acc_next_s = acc_r;
        end
        r_shift_s = {rem_r, shreg_r[WIDTH-1]};
        if (r_shift_s >= {1'b0, divisor_r}) begin
            rem_next_s = r_shift_s[WIDTH-1:0] - divisor_r;
            q_next_s   = {shreg_r[WIDTH-2:0], 1'b1};
        end else begin
            rem_next_s = r_shift_s[WIDTH-1:0];
            q_next_s   = {shreg_r[WIDTH-2:0], 1'b0};
        end
    end

    // Outputs present the final iteration's values so the caller captures them on that same edge
    assign done     = busy_r && (cnt_r == CW'(WIDTH - 1));
    assign quo_prod = div_r ? q_next_s : acc_next_s[WIDTH-1:0];
    assign rem      = rem_next_s;
`ifdef ALU_OVERFLOW_EN
    assign prod_hi_nz = |acc_next_s[PW-1:WIDTH];
`endif

    // Iteration state: operand load on start, one step per edge while busy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_r    <= 1'b0;
            div_r     <= 1'b0;
            cnt_r     <= {CW{1'b0}};
            mcand_r   <= {PW{1'b0}};
            acc_r     <= {PW{1'b0}};
            shreg_r   <= {WIDTH{1'b0}};
            divisor_r <= {WIDTH{1'b0}};
            rem_r     <= {WIDTH{1'b0}};
        end else if (start) begin
            busy_r    <= 1'b1;
            div_r     <= op_div;
            cnt_r     <= {CW{1'b0}};
            mcand_r   <= PW'(a);
            acc_r     <= {PW{1'b0}};
            shreg_r   <= op_div ? a : b;
            divisor_r <= b;
            rem_r     <= {WIDTH{1'b0}};
        end else if (busy_r) begin
            busy_r  <= !done;
            cnt_r   <= cnt_r + CW'(1);
            acc_r   <= acc_next_s;
            mcand_r <= mcand_r << 1;
            shreg_r <= div_r ? q_next_s : (shreg_r >> 1);
            rem_r   <= rem_next_s;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle ops plus iterative MUL/DIV/REM, with a held registered result.
// ALU_OVERFLOW_EN adds the registered overflow output.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src_A,
    input  logic [WIDTH-1:0] src_B,
    input  logic [3:0]       ALU_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_result,
    output logic             zero,
    output logic             div_by_zero
`ifdef ALU_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int SHW = $clog2(WIDTH);

    alu_state_t       state_r;
    alu_state_t       next_state_s;
    logic [3:0]       op_s;
    logic [3:0]       op_r;
    logic [WIDTH-1:0] result_r;
    logic             dbz_r;
    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] diff_s;
    logic [WIDTH-1:0] sc_result_s;
    logic             dbz_s;
    logic             start_s;
    logic             load_sc_s;
    logic             cap_eng_s;
    logic             op_div_s;
    logic             eng_done_s;
    logic [WIDTH-1:0] eng_quo_s;
    logic [WIDTH-1:0] eng_rem_s;

    assign op_s      = ALU_control;
    assign sum_s     = src_A + src_B;
    assign diff_s    = src_A - src_B;
    assign dbz_s     = ((op_s == ALU_DIV) || (op_s == ALU_REM)) && (src_B == {WIDTH{1'b0}});
    assign op_div_s  = (op_s != ALU_MUL);
    assign cap_eng_s = (state_r == BUSY) && eng_done_s;

    // DIV/REM only reach this path with a zero divisor; unknown codes fall through to ADD
    always_comb begin
        sc_result_s = sum_s;
        case (op_s)
            ALU_AND:  sc_result_s = src_A & src_B;
            ALU_OR:   sc_result_s = src_A | src_B;
            ALU_NOR:  sc_result_s = ~(src_A | src_B);
            ALU_XOR:  sc_result_s = src_A ^ src_B;
            ALU_SLL1: sc_result_s = src_A << 1;
            ALU_SRL1: sc_result_s = src_A >> 1;
            ALU_SLLV: sc_result_s = src_A << src_B[SHW-1:0];
            ALU_SRLV: sc_result_s = src_A >> src_B[SHW-1:0];
            ALU_SUB:  sc_result_s = diff_s;
            ALU_DIV:  sc_result_s = {WIDTH{1'b1}};
            ALU_REM:  sc_result_s = src_A;
            ALU_SLT:  sc_result_s = {{(WIDTH-1){1'b0}}, (src_A < src_B)};
            ALU_SEQ:  sc_result_s = {{(WIDTH-1){1'b0}}, (src_A == src_B)};
            default:  sc_result_s = sum_s;
        endcase
    end

    // Next-state and handshake decode; a DONE with out_ready behaves like IDLE for acceptance
    always_comb begin
        next_state_s = state_r;
        in_ready     = 1'b0;
        start_s      = 1'b0;
        load_sc_s    = 1'b0;
        case (state_r)
            IDLE: in_ready = 1'b1;
            BUSY: begin
                if (eng_done_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = BUSY;
                end
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DONE;
                end
            end
            default: next_state_s = IDLE;
        endcase
        if (in_valid && in_ready) begin
            if (is_iterative(op_s) && !dbz_s) begin
                start_s      = 1'b1;
                next_state_s = BUSY;
            end else begin
                load_sc_s    = 1'b1;
                next_state_s = DONE;
            end
        end else begin
            start_s = 1'b0;
        end
    end

    // FSM state, the iterative opcode in flight, and the held result/flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            op_r     <= 4'b0000;
            result_r <= {WIDTH{1'b0}};
            dbz_r    <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (start_s) begin
                op_r <= op_s;
            end
            if (load_sc_s) begin
                result_r <= sc_result_s;
                dbz_r    <= dbz_s;
            end else if (cap_eng_s) begin
                result_r <= (op_r == ALU_REM) ? eng_rem_s : eng_quo_s;
                dbz_r    <= 1'b0;
            end
        end
    end

    assign out_valid   = (state_r == DONE);
    assign ALU_result  = result_r;
    assign zero        = (result_r == {WIDTH{1'b0}});
    assign div_by_zero = dbz_r;

`ifdef ALU_OVERFLOW_EN
    logic sc_ovf_s;
    logic eng_hi_s;
    logic ovf_r;

    // Signed overflow for the adder path; MUL overflow comes from the engine's high product bits
    always_comb begin
        case (op_s)
            ALU_SUB: sc_ovf_s = (src_A[WIDTH-1] != src_B[WIDTH-1]) && (diff_s[WIDTH-1] != src_A[WIDTH-1]);
            ALU_AND, ALU_OR, ALU_NOR, ALU_XOR, ALU_SLL1, ALU_SRL1, ALU_SLLV, ALU_SRLV,
            ALU_MUL, ALU_DIV, ALU_REM, ALU_SLT, ALU_SEQ: sc_ovf_s = 1'b0;
            default: sc_ovf_s = (src_A[WIDTH-1] == src_B[WIDTH-1]) && (sum_s[WIDTH-1] != src_A[WIDTH-1]);
        endcase
    end

    // Overflow flag is captured alongside the result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_r <= 1'b0;
        end else if (load_sc_s) begin
            ovf_r <= sc_ovf_s;
        end else if (cap_eng_s) begin
            ovf_r <= (op_r == ALU_MUL) && eng_hi_s;
        end
    end

    assign overflow = ovf_r;
`endif

    iter_muldiv #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start_s),
        .op_div   (op_div_s),
        .a        (src_A),
        .b        (src_B),
        .done     (eng_done_s),
        .quo_prod (eng_quo_s),
        .rem      (eng_rem_s)
`ifdef ALU_OVERFLOW_EN
        ,
        .prod_hi_nz(eng_hi_s)
`endif
    );

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32): directed cases plus randomized ops vs. an arithmetic model.
// Checks the overflow output too when ALU_OVERFLOW_EN is defined.
module tb_seq_alu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] src_A;
    logic [W-1:0] src_B;
    logic [3:0]   ALU_control;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] ALU_result;
    logic         zero;
    logic         div_by_zero;
`ifdef ALU_OVERFLOW_EN
    logic         overflow;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .src_A       (src_A),
        .src_B       (src_B),
        .ALU_control (ALU_control),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ALU_result  (ALU_result),
        .zero        (zero),
        .div_by_zero (div_by_zero)
`ifdef ALU_OVERFLOW_EN
        ,
        .overflow    (overflow)
`endif
    );

    function automatic logic [W-1:0] model_res(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint unsigned p;
        case (op)
            4'b1000: return a & b;
            4'b1001: return a | b;
            4'b1011: return ~(a | b);
            4'b1010: return a ^ b;
            4'b0100: return a * 2;
            4'b0101: return a / 2;
            4'b0110: return a << (b % W);
            4'b0111: return a >> (b % W);
            4'b0001: return a - b;
            4'b0010: begin p = longint'(a) * longint'(b); return p[W-1:0]; end
            4'b0011: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'b1100: return (b == 0) ? a : a % b;
            4'b1110: return (a < b) ? 32'd1 : 32'd0;
            4'b1111: return (a == b) ? 32'd1 : 32'd0;
            default: return a + b;
        endcase
    endfunction

    function automatic logic model_ovf(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint s;
        longint lim;
        longint unsigned p;
        lim = longint'(1) << (W - 1);
        case (op)
            4'b0001: s = longint'($signed(a)) - longint'($signed(b));
            4'b0010: begin p = longint'(a) * longint'(b); return (p >> W) != 0; end
            4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b1010,
            4'b1011, 4'b1100, 4'b1110, 4'b1111: return 1'b0;
            default: s = longint'($signed(a)) + longint'($signed(b));
        endcase
        return (s >= lim) || (s < -lim);
    endfunction

    // Issue one op with out_ready=1, then check latency, busy in_ready, result and flags.
    task automatic run_op(input string name, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp);
        int   n;
        int   exp_lat;
        logic exp_dbz;
        logic rdy_bad;
        exp_dbz = ((op == 4'b0011) || (op == 4'b1100)) && (b == 0);
        exp_lat = ((op == 4'b0010) || (((op == 4'b0011) || (op == 4'b1100)) && (b != 0))) ? W + 1 : 1;
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; ALU_control = op; src_A = a; src_B = b;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL %s accept: in_ready got %b want 1", name, in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; src_A = $urandom; src_B = $urandom; ALU_control = 4'($urandom);
        n = 1; rdy_bad = 1'b0;
        while (out_valid !== 1'b1 && n < W + 8) begin
            if (in_ready !== 1'b0) rdy_bad = 1'b1;
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n != exp_lat) begin
            miscompares++; $display("FAIL %s latency: got %0d want %0d", name, n, exp_lat);
        end
        if (exp_lat > 1) begin
            vectors++;
            if (rdy_bad) begin
                miscompares++; $display("FAIL %s busy_in_ready: got 1 want 0 while busy", name);
            end
        end
        vectors++;
        if (ALU_result !== exp || zero !== (exp == 0) || div_by_zero !== exp_dbz) begin
            miscompares++;
            $display("FAIL %s result: got %h zero=%b dbz=%b want %h zero=%b dbz=%b",
                     name, ALU_result, zero, div_by_zero, exp, (exp == 0), exp_dbz);
        end
`ifdef ALU_OVERFLOW_EN
        vectors++;
        if (overflow !== model_ovf(op, a, b)) begin
            miscompares++; $display("FAIL %s overflow: got %b want %b", name, overflow, model_ovf(op, a, b));
        end
`endif
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        src_A = '0; src_B = '0; ALU_control = 4'b0000;
        #12;
        vectors++;
        if (out_valid !== 1'b0 || ALU_result !== 0 || zero !== 1'b1 || in_ready !== 1'b1 || div_by_zero !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: got ov=%b res=%h zero=%b ir=%b dbz=%b want 0 0 1 1 0",
                     out_valid, ALU_result, zero, in_ready, div_by_zero);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_add_sub();
        run_op("add_5_7", 4'b0000, 32'd5, 32'd7, 32'd12);
        run_op("sub_9_9", 4'b0001, 32'd9, 32'd9, 32'd0);
        run_op("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'd2, 32'd1);
        run_op("sub_ovf", 4'b0001, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF);
    endtask

    task automatic test_muldiv();
        run_op("mul_6_7", 4'b0010, 32'd6, 32'd7, 32'd42);
        run_op("mul_hi", 4'b0010, 32'h0001_0000, 32'h0001_0000, 32'd0);
        run_op("div_100_7", 4'b0011, 32'd100, 32'd7, 32'd14);
        run_op("rem_100_7", 4'b1100, 32'd100, 32'd7, 32'd2);
        run_op("div_max_1", 4'b0011, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
    endtask

    task automatic test_div_zero();
        run_op("div_5_0", 4'b0011, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_op("rem_5_0", 4'b1100, 32'd5, 32'd0, 32'd5);
    endtask

    task automatic test_shift_cmp();
        run_op("sllv_31", 4'b0110, 32'd1, 32'd31, 32'h8000_0000);
        run_op("srlv_4", 4'b0111, 32'hF000_0000, 32'd4, 32'h0F00_0000);
        run_op("sll1", 4'b0100, 32'h8000_0001, 32'd0, 32'h0000_0002);
        run_op("srl1", 4'b0101, 32'h8000_0001, 32'd0, 32'h4000_0000);
        run_op("slt_3_4", 4'b1110, 32'd3, 32'd4, 32'd1);
        run_op("slt_4_3", 4'b1110, 32'd4, 32'd3, 32'd0);
        run_op("seq_7_7", 4'b1111, 32'd7, 32'd7, 32'd1);
        run_op("nor", 4'b1011, 32'h0F0F_0000, 32'h0000_00FF, 32'hF0F0_FF00);
        run_op("op_1101", 4'b1101, 32'd2, 32'd3, 32'd5);
    endtask

    task automatic test_random();
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
            run_op("random", op, a, b, model_res(op, a, b));
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; ALU_control = 4'b0000;
        src_A = 32'h0000_1234; src_B = 32'h0000_1111;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || ALU_result !== 32'h0000_2345 || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold: got ov=%b res=%h ir=%b want 1 00002345 0", out_valid, ALU_result, in_ready);
            end
            if (i == 1) begin
                in_valid = 1'b1; ALU_control = 4'b0001; src_A = 32'd77; src_B = 32'd1;
            end
            @(negedge clk);
        end
        out_ready = 1'b1; in_valid = 1'b1; ALU_control = 4'b1010;
        src_A = 32'h0000_00F0; src_B = 32'h0000_00FF;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
            miscompares++; $display("FAIL same_edge_ready: got ir=%b ov=%b want 1 1", in_ready, out_valid);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || ALU_result !== 32'h0000_000F) begin
            miscompares++; $display("FAIL same_edge_xor: got ov=%b res=%h want 1 0000000f", out_valid, ALU_result);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]   codes [15] = '{4'b0000, 4'b0001, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000,
                                     4'b1001, 4'b1010, 4'b1011, 4'b1110, 4'b1111, 4'b1101, 4'b0011, 4'b1100};
        logic [W-1:0] exp_q [$];
        logic         dbz_q [$];
        logic [W-1:0] e;
        logic         d;
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        out_ready = 1'b1;
        for (int i = 0; i <= 12; i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = exp_q.pop_front();
                d = dbz_q.pop_front();
                vectors++;
                if (out_valid !== 1'b1 || ALU_result !== e || div_by_zero !== d || in_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b[%0d]: got ov=%b res=%h dbz=%b ir=%b want 1 %h %b 1",
                             i - 1, out_valid, ALU_result, div_by_zero, in_ready, e, d);
                end
            end
            if (i < 12) begin
                op = codes[$urandom_range(0, 14)];
                a  = $urandom;
                b  = ((op == 4'b0011) || (op == 4'b1100)) ? 32'd0 : $urandom;
                in_valid = 1'b1; ALU_control = op; src_A = a; src_B = b;
                exp_q.push_back(model_res(op, a, b));
                dbz_q.push_back((op == 4'b0011) || (op == 4'b1100));
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
        end
    endtask

    task automatic test_reset_mid_busy();
        logic seen;
        run_op("pre_reset_add", 4'b0000, 32'd5, 32'd7, 32'd12);
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; ALU_control = 4'b0010; src_A = 32'd6; src_B = 32'd7;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++; $display("FAIL mid_busy: got ir=%b ov=%b want 0 0", in_ready, out_valid);
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || ALU_result !== 0 || in_ready !== 1'b1 || zero !== 1'b1 || div_by_zero !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_reset: got ov=%b res=%h ir=%b zero=%b dbz=%b want 0 0 1 1 0",
                     out_valid, ALU_result, in_ready, zero, div_by_zero);
        end
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (W + 4) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            miscompares++; $display("FAIL aborted_result: got out_valid 1 want 0 after abort");
        end
        run_op("post_reset_add", 4'b0000, 32'd1, 32'd1, 32'd2);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_add_sub();
        test_muldiv();
        test_div_zero();
        test_shift_cmp();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
